pdm_transmitter: RTL

- PCM-to-PDM transmitter: the transmit end of the PDM microphone link that the audio capture path receives.
- Accepts signed PCM samples through a valid/ready FIFO and drives pdm_clk_o/pdm_data_o using a first-order sigma-delta modulator.
- Used as an on-chip microphone model for APU loopback and as a PDM output stage for external DACs/amplifiers.

---
 rtl/pdm_transmitter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pdm_transmitter.sv
// PCM-to-PDM transmitter: a sample FIFO feeding a first-order sigma-delta
// modulator that drives a divided PDM bit clock and bitstream.
//
// Handshake: a sample is accepted on any rising clk_i edge where
// sample_valid_i and sample_ready_o are both high; sample_ready_o depends only
// on FIFO occupancy, and a sample offered while it is low is dropped.
module pdm_transmitter #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int OSR          = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enable_i,
   input  logic [7:0]                    clock_divider_i,
   input  logic [SAMPLE_WIDTH-1:0]       sample_i,
   input  logic                          sample_valid_i,
   output logic                          sample_ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          underrun_o,
   output logic                          busy_o,
   output logic                          pdm_clk_o,
   output logic                          pdm_data_o
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int BIT_W  = $clog2(OSR);
   localparam int ACC_W  = SAMPLE_WIDTH + 2;
   // Full-scale feedback value 2^(W-1) at accumulator width.
   localparam logic signed [ACC_W-1:0] FS = {3'b001, {(SAMPLE_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t state, state_next;

   // FIFO storage and bookkeeping
   logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]        count;
   logic                    full, empty, push, pop;
   logic [SAMPLE_WIDTH-1:0] head;

   // Modulator / bit-clock state
   logic signed [ACC_W-1:0] acc;
   logic [SAMPLE_WIDTH-1:0] cur_sample;
   logic [7:0]              div, div_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic                    div_tc;

   // FSM strobes
   logic load, bit_step, wrap, stop;

   // Next-bit arithmetic
   logic [SAMPLE_WIDTH-1:0] operand;
   logic signed [ACC_W-1:0] operand_ext, feedback, acc_next;
   logic                    bit_val;

   assign full           = (count == CNT_W'(FIFO_DEPTH));
   assign empty          = (count == '0);
   assign push           = sample_valid_i && !full;
   assign head           = mem[rd_ptr];
   assign sample_ready_o = !full;
   assign fifo_count_o   = count;
   assign busy_o         = (state != IDLE);
   assign div_tc         = (div_cnt == div - 8'd1);

   // FIFO data array write port
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= sample_i;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next state and per-cycle control strobes
   always_comb begin
      state_next = state;
      load       = 1'b0;
      bit_step   = 1'b0;
      wrap       = 1'b0;
      stop       = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i) state_next = PRIME;
         end
         PRIME: begin
            if (!enable_i) begin
               state_next = IDLE;
            end else if (!empty) begin
               load       = 1'b1;
               pop        = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            // Only the 1->0 toggle of pdm_clk_o advances the bitstream.
            if (div_tc && pdm_clk_o) begin
               if (!enable_i) begin
                  stop       = 1'b1;
                  state_next = IDLE;
               end else begin
                  bit_step = 1'b1;
                  if (bit_cnt == BIT_W'(OSR - 1)) begin
                     wrap = 1'b1;
                     pop  = !empty;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sigma-delta step: choose the sample feeding this bit, then quantise.
   always_comb begin
      operand = cur_sample;
      if (load)      operand = head;
      else if (wrap) operand = empty ? '0 : head;
      operand_ext = {{2{operand[SAMPLE_WIDTH-1]}}, operand};
      bit_val     = !acc[ACC_W-1];
      feedback    = bit_val ? FS : -FS;
      acc_next    = acc + operand_ext - feedback;
   end

   // Bit clock divider, bit/sample sequencing and modulator registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc        <= '0;
         cur_sample <= '0;
         div        <= 8'd1;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         pdm_clk_o  <= 1'b0;
         pdm_data_o <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         underrun_o <= 1'b0;
         if (state == RUN) begin
            if (div_tc) begin
               div_cnt   <= '0;
               pdm_clk_o <= !pdm_clk_o;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end
         if (load) begin
            cur_sample <= head;
            div        <= (clock_divider_i == 8'd0) ? 8'd1 : clock_divider_i;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            pdm_clk_o  <= 1'b0;
         end
         if (bit_step) begin
            if (wrap) begin
               bit_cnt    <= '0;
               cur_sample <= empty ? '0 : head;
               underrun_o <= empty;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if (load || bit_step) begin
            acc        <= acc_next;
            pdm_data_o <= bit_val;
         end
         if (stop) begin
            acc        <= '0;
            pdm_data_o <= 1'b0;
            pdm_clk_o  <= 1'b0;
            div_cnt    <= '0;
         end
      end
   end

endmodule
